// File: rtl/instr_buffer_if.sv
// rtl/instr_buffer_if.sv - decode, fetch-credit and issue signals of the per-warp instruction buffer
interface instr_buffer_if #(
  parameter int NUM_WARPS = 8,
  parameter int PAYLOAD_W = 64
);
  logic [NUM_WARPS-1:0] Valid_ID0_IB;
  logic [PAYLOAD_W-1:0] Payload_ID0_IB;
  logic [NUM_WARPS-1:0] Valid_ID1_IB;
  logic [PAYLOAD_W-1:0] Payload_ID1_IB;
  logic [NUM_WARPS-1:0] Grant_RR_IB;
  logic [NUM_WARPS-1:0] Flush_SIMT_IB;
  logic [NUM_WARPS-1:0] Issue_Grant_IB;
  logic [NUM_WARPS-1:0] Req_IB_PC;
  logic [NUM_WARPS-1:0] Ready_IB_Issue;
  logic [PAYLOAD_W-1:0] Issue_Payload_IB;
  logic                 Issue_Valid_IB;
  logic                 Overflow_IB;

  modport master (
    output Valid_ID0_IB, Payload_ID0_IB, Valid_ID1_IB, Payload_ID1_IB,
    output Grant_RR_IB, Flush_SIMT_IB, Issue_Grant_IB,
    input  Req_IB_PC, Ready_IB_Issue, Issue_Payload_IB, Issue_Valid_IB, Overflow_IB
  );

  modport slave (
    input  Valid_ID0_IB, Payload_ID0_IB, Valid_ID1_IB, Payload_ID1_IB,
    input  Grant_RR_IB, Flush_SIMT_IB, Issue_Grant_IB,
    output Req_IB_PC, Ready_IB_Issue, Issue_Payload_IB, Issue_Valid_IB, Overflow_IB
  );
endinterface

// File: rtl/instr_buffer.sv
// rtl/instr_buffer.sv - per-warp instruction FIFOs with dual-lane write, single pop and fetch credits
module instr_buffer #(
  parameter int NUM_WARPS = 8,
  parameter int DEPTH     = 4,
  parameter int PAYLOAD_W = 64
) (
  input logic            clk,
  input logic            rst,
  instr_buffer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;
  typedef logic [CW:0]   wide_t;

  localparam wide_t DEPTH_W = wide_t'(DEPTH);

  logic [PAYLOAD_W-1:0] mem [NUM_WARPS][DEPTH];

  ptr_t rd_ptr   [NUM_WARPS];
  ptr_t wr_ptr   [NUM_WARPS];
  cnt_t count    [NUM_WARPS];
  cnt_t inflight [NUM_WARPS];

  ptr_t rd_ptr_n   [NUM_WARPS];
  ptr_t wr_ptr_n   [NUM_WARPS];
  cnt_t count_n    [NUM_WARPS];
  cnt_t inflight_n [NUM_WARPS];
  ptr_t waddr0     [NUM_WARPS];
  ptr_t waddr1     [NUM_WARPS];

  logic [NUM_WARPS-1:0] wen0;
  logic [NUM_WARPS-1:0] wen1;
  logic [NUM_WARPS-1:0] drop;
  logic [NUM_WARPS-1:0] ready;
  logic [NUM_WARPS-1:0] req;
  logic [NUM_WARPS-1:0] v0_eff;
  logic [NUM_WARPS-1:0] v1_eff;
  logic                 lane0_ok;
  logic                 lane1_ok;
  logic                 overflow;

  // A lane whose valid is not one-hot writes nothing and is reported as an error
  assign lane0_ok = $onehot0(bus.Valid_ID0_IB);
  assign lane1_ok = $onehot0(bus.Valid_ID1_IB);
  assign v0_eff   = lane0_ok ? bus.Valid_ID0_IB : '0;
  assign v1_eff   = lane1_ok ? bus.Valid_ID1_IB : '0;

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      ready[w] = (count[w] != '0);
      req[w]   = (wide_t'(count[w]) + wide_t'(inflight[w])) < DEPTH_W;
    end
  end

  always_comb begin
    wen0 = '0;
    wen1 = '0;
    drop = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      logic  pop;
      logic  acc0;
      logic  acc1;
      wide_t free;
      wide_t base;
      wide_t arr;
      wide_t nxt;

      pop  = bus.Issue_Grant_IB[w] & ready[w];
      // Pop is applied before the writes, so a full popping warp still accepts one write
      free = DEPTH_W - wide_t'(count[w]) + wide_t'(pop);
      acc0 = v0_eff[w] & (free != '0);
      acc1 = v1_eff[w] & ((free - wide_t'(acc0)) != '0);

      base = wide_t'(inflight[w]) + wide_t'(bus.Grant_RR_IB[w]);
      arr  = wide_t'(v0_eff[w]) + wide_t'(v1_eff[w]);
      nxt  = (base > arr) ? base - arr : '0;
      if (nxt > DEPTH_W) begin
        nxt = DEPTH_W;
      end

      rd_ptr_n[w]   = rd_ptr[w] + ptr_t'(pop);
      wr_ptr_n[w]   = wr_ptr[w] + ptr_t'(acc0) + ptr_t'(acc1);
      count_n[w]    = cnt_t'(wide_t'(count[w]) - wide_t'(pop) + wide_t'(acc0) + wide_t'(acc1));
      inflight_n[w] = cnt_t'(nxt);
      waddr0[w]     = wr_ptr[w];
      waddr1[w]     = wr_ptr[w] + ptr_t'(acc0);
      wen0[w]       = acc0;
      wen1[w]       = acc1;
      drop[w]       = (v0_eff[w] & ~acc0) | (v1_eff[w] & ~acc1);

      // Flush wins over every same-cycle write, pop and grant on this warp
      if (bus.Flush_SIMT_IB[w]) begin
        rd_ptr_n[w]   = '0;
        wr_ptr_n[w]   = '0;
        count_n[w]    = '0;
        inflight_n[w] = '0;
        wen0[w]       = 1'b0;
        wen1[w]       = 1'b0;
        drop[w]       = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        rd_ptr[w]   <= '0;
        wr_ptr[w]   <= '0;
        count[w]    <= '0;
        inflight[w] <= '0;
      end
      overflow <= 1'b0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        rd_ptr[w]   <= rd_ptr_n[w];
        wr_ptr[w]   <= wr_ptr_n[w];
        count[w]    <= count_n[w];
        inflight[w] <= inflight_n[w];
      end
      overflow <= overflow | ~lane0_ok | ~lane1_ok | (|drop);
    end
  end

  // Storage holds no reset; only pointers and counts define what is valid
  always_ff @(posedge clk) begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (wen0[w]) begin
        mem[w][waddr0[w]] <= bus.Payload_ID0_IB;
      end
      if (wen1[w]) begin
        mem[w][waddr1[w]] <= bus.Payload_ID1_IB;
      end
    end
  end

  always_comb begin
    bus.Issue_Payload_IB = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (bus.Issue_Grant_IB[w]) begin
        bus.Issue_Payload_IB = bus.Issue_Payload_IB | mem[w][rd_ptr[w]];
      end
    end
  end

  assign bus.Issue_Valid_IB = |(bus.Issue_Grant_IB & ready);
  assign bus.Ready_IB_Issue = ready;
  assign bus.Req_IB_PC      = req;
  assign bus.Overflow_IB    = overflow;
endmodule

// File: tb/tb_instr_buffer.sv
// tb/tb_instr_buffer.sv - directed self-checking bench for instr_buffer
module tb_instr_buffer;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  instr_buffer_if #(.NUM_WARPS(8), .PAYLOAD_W(64)) ib ();

  instr_buffer #(.NUM_WARPS(8), .DEPTH(4), .PAYLOAD_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ib.Valid_ID0_IB   = '0;
    ib.Payload_ID0_IB = '0;
    ib.Valid_ID1_IB   = '0;
    ib.Payload_ID1_IB = '0;
    ib.Grant_RR_IB    = '0;
    ib.Flush_SIMT_IB  = '0;
    ib.Issue_Grant_IB = '0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    tick();

    check("reset_req",     64'(ib.Req_IB_PC),        64'hFF);
    check("reset_ready",   64'(ib.Ready_IB_Issue),   64'h00);
    check("reset_ivalid",  64'(ib.Issue_Valid_IB),   64'h0);
    check("reset_ovf",     64'(ib.Overflow_IB),      64'h0);
    check("reset_payload", ib.Issue_Payload_IB,      64'h0);

    // Ordered fill and drain on warp 0
    ib.Grant_RR_IB = 8'h01;
    tick(); tick(); tick();
    check("req_after_3_grants", 64'(ib.Req_IB_PC), 64'hFF);
    tick();
    check("req_after_4_grants", 64'(ib.Req_IB_PC), 64'hFE);
    ib.Grant_RR_IB = '0;
    for (int i = 1; i <= 4; i++) begin
      ib.Valid_ID0_IB   = 8'h01;
      ib.Payload_ID0_IB = 64'(i);
      tick();
      if (i == 1) check("ready_after_first_write", 64'(ib.Ready_IB_Issue), 64'h01);
    end
    idle_inputs();
    check("req_w0_full", 64'(ib.Req_IB_PC), 64'hFE);
    for (int i = 1; i <= 4; i++) begin
      ib.Issue_Grant_IB = 8'h01;
      #1;
      check("drain_w0_payload", ib.Issue_Payload_IB, 64'(i));
      check("drain_w0_valid",   64'(ib.Issue_Valid_IB), 64'h1);
      tick();
    end
    #1;
    check("drain_w0_empty_valid", 64'(ib.Issue_Valid_IB), 64'h0);
    check("drain_w0_ready",       64'(ib.Ready_IB_Issue), 64'h00);
    check("drain_w0_req",         64'(ib.Req_IB_PC),      64'hFF);
    idle_inputs();

    // Dual-lane write to warps 2 and 7
    ib.Valid_ID0_IB   = 8'h04;
    ib.Payload_ID0_IB = 64'hAAAA_0000_0000_000A;
    ib.Valid_ID1_IB   = 8'h80;
    ib.Payload_ID1_IB = 64'hBBBB_0000_0000_000B;
    tick();
    idle_inputs();
    check("dual_ready", 64'(ib.Ready_IB_Issue), 64'h84);
    ib.Issue_Grant_IB = 8'h80;
    #1;
    check("dual_pop_w7", ib.Issue_Payload_IB, 64'hBBBB_0000_0000_000B);
    tick();
    ib.Issue_Grant_IB = 8'h04;
    #1;
    check("dual_pop_w2", ib.Issue_Payload_IB, 64'hAAAA_0000_0000_000A);
    tick();
    idle_inputs();
    check("dual_drained", 64'(ib.Ready_IB_Issue), 64'h00);
    check("dual_ovf",     64'(ib.Overflow_IB),    64'h0);

    // Full warp 3: write with pop accepted, write without pop discarded
    for (int i = 0; i < 4; i++) begin
      ib.Valid_ID0_IB   = 8'h08;
      ib.Payload_ID0_IB = 64'(8'h31 + i);
      tick();
    end
    idle_inputs();
    check("full_w3_req", 64'(ib.Req_IB_PC), 64'hF7);
    ib.Valid_ID0_IB   = 8'h08;
    ib.Payload_ID0_IB = 64'h35;
    ib.Issue_Grant_IB = 8'h08;
    #1;
    check("full_w3_head", ib.Issue_Payload_IB, 64'h31);
    tick();
    idle_inputs();
    check("full_w3_popwrite_ovf",   64'(ib.Overflow_IB),    64'h0);
    check("full_w3_popwrite_ready", 64'(ib.Ready_IB_Issue), 64'h08);
    check("full_w3_popwrite_req",   64'(ib.Req_IB_PC),      64'hF7);
    ib.Valid_ID0_IB   = 8'h08;
    ib.Payload_ID0_IB = 64'h36;
    tick();
    idle_inputs();
    check("full_w3_drop_ovf", 64'(ib.Overflow_IB), 64'h1);
    for (int i = 0; i < 4; i++) begin
      ib.Issue_Grant_IB = 8'h08;
      #1;
      check("full_w3_drain", ib.Issue_Payload_IB, 64'(8'h32 + i));
      tick();
    end
    idle_inputs();
    check("full_w3_empty",   64'(ib.Ready_IB_Issue), 64'h00);
    check("ovf_sticky",      64'(ib.Overflow_IB),    64'h1);

    // Flush warp 5 holding 2 entries with 1 fetch in flight
    ib.Grant_RR_IB = 8'h20;
    tick(); tick(); tick();
    ib.Grant_RR_IB = '0;
    ib.Valid_ID0_IB = 8'h20;
    ib.Payload_ID0_IB = 64'h51;
    tick();
    ib.Payload_ID0_IB = 64'h52;
    tick();
    check("pre_flush_ready", 64'(ib.Ready_IB_Issue), 64'h20);
    ib.Payload_ID0_IB = 64'h53;
    ib.Flush_SIMT_IB  = 8'h20;
    ib.Grant_RR_IB    = 8'h20;
    tick();
    idle_inputs();
    check("flush_ready", 64'(ib.Ready_IB_Issue), 64'h00);
    check("flush_req",   64'(ib.Req_IB_PC),      64'hFF);
    ib.Grant_RR_IB = 8'h20;
    tick(); tick(); tick();
    check("flush_inflight_3", 64'(ib.Req_IB_PC), 64'hFF);
    tick();
    check("flush_inflight_4", 64'(ib.Req_IB_PC), 64'hDF);
    idle_inputs();

    // Asynchronous reset between edges while warps 0-3 hold entries
    ib.Valid_ID0_IB = 8'h01; ib.Payload_ID0_IB = 64'hC0;
    ib.Valid_ID1_IB = 8'h02; ib.Payload_ID1_IB = 64'hC1;
    tick();
    ib.Valid_ID0_IB = 8'h04; ib.Payload_ID0_IB = 64'hC2;
    ib.Valid_ID1_IB = 8'h08; ib.Payload_ID1_IB = 64'hC3;
    tick();
    idle_inputs();
    ib.Issue_Grant_IB = 8'h01;
    #1;
    check("pre_rst_ready",  64'(ib.Ready_IB_Issue), 64'h0F);
    check("pre_rst_ivalid", 64'(ib.Issue_Valid_IB), 64'h1);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_ready",  64'(ib.Ready_IB_Issue), 64'h00);
    check("async_rst_req",    64'(ib.Req_IB_PC),      64'hFF);
    check("async_rst_ivalid", 64'(ib.Issue_Valid_IB), 64'h0);
    check("async_rst_ovf",    64'(ib.Overflow_IB),    64'h0);
    idle_inputs();
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
